goto_cond_sequencer: RTL and testbench
======================================

// Module: goto_cond_sequencer
// PURPOSE
//  Consumes the 3-bit CCR {carry, sign, zero} and executes the 3-byte conditional GOTO instruction.
//  Fetches the two address operand bytes over a req/ack memory port.
//  Evaluates the opcode's condition bits against the CCR.
//  Drives PC load and, for call forms, a link-register load.
//  Sits between the instruction decoder and the PC/XY register units.
// PARAMETERS
//  ADDR_W  16  address/PC width
//  DATA_W  8   memory data width; ADDR_W == 2*DATA_W
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       async active-low reset
//  start      in   1       decoder: GOTO opcode present; pulse
//  opcode     in   8       GOTO opcode, fields 11_d_s_c_z_nz_x
//  ccr        in   3       {carry, sign, zero} from the CCR register
//  pc_cur     in   ADDR_W  PC, pointing at the first operand byte
//  mem_ack    in   1       memory read complete; mem_data valid
//  mem_data   in   DATA_W  read data
//  mem_req    out  1       memory read request
//  mem_addr   out  ADDR_W  read address
//  pc_load    out  1       1-cycle PC load strobe
//  pc_next    out  ADDR_W  value to load into PC
//  link_load  out  1       1-cycle link (XY) load strobe
//  link_addr  out  ADDR_W  return address
//  busy       out  1       high from the cycle after start until done
//  done       out  1       1-cycle completion pulse, coincident with pc_load
//  taken      out  1       valid when done is high: branch taken
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. All outputs 0. Internal latches cleared.
//  IDLE: on start, latch opcode, ccr snapshot and op_ptr=pc_cur; go to FETCH_HI.
//    CCR changes after start are ignored. start while busy is ignored.
//  FETCH_HI: mem_req=1, mem_addr=op_ptr. Hold until mem_ack is sampled high.
//    On ack: capture hi, op_ptr+=1, go to FETCH_LO.
//  FETCH_LO: same as FETCH_HI, capturing lo. On ack, evaluate the condition:
//    cond = (s&sign) | (c&carry) | (z&zero) | (nz&~zero).
//    If s,c,z,nz are all 0, the branch is unconditional (cond=1).
//    Next state: LINK if cond & d, else JUMP.
//  LINK: link_load=1, link_addr=op_ptr+1 (the address after the instruction). Go to JUMP.
//  JUMP: pc_load=1, done=1, taken=cond. Go to IDLE.
//    pc_next = cond ? {hi,lo} : op_ptr+1.
//  mem_ack while mem_req=0 is ignored. mem_req never drops before ack.
//  All address arithmetic is mod 2^ADDR_W. Example, pc_cur=FFFF:
//    hi read at FFFF, lo read at 0000, fall-through/link address 0001.
//  Latency with zero-wait ack: done 3 cycles after start (4 with LINK); +1 per wait cycle.
// CONFIGURATION
//  EARLY_EVAL_EN defined: condition is evaluated at start from the snapshot.
//    Not taken: skip both fetches; IDLE->JUMP; pc_next=pc_cur+2; done 1 cycle after start.
//  EARLY_EVAL_EN undefined: both operand bytes are always fetched, as above.
// STRUCTURE
//  Package relay_pkg holds:
//    gcs_state_t enum {IDLE, FETCH_HI, FETCH_LO, LINK, JUMP}
//    CCR bit indices CCR_C=2, CCR_S=1, CCR_Z=0
//    opcode field indices OP_D=5, OP_S=4, OP_C=3, OP_Z=2, OP_NZ=1
//  Sub-module goto_cond_eval: combinational (opcode, ccr) -> cond; shared with decoder lookahead.
// TESTING
//  1. op=C0 (unconditional), pc_cur=0100, mem returns 12,34 with 0 wait
//     -> reads at 0100,0101; pc_next=1234; taken=1; done 3 cycles after start.
//  2. op=C4 (z), ccr=000, mem 56,78
//     -> taken=0; pc_next=0102 (with EARLY_EVAL_EN: no mem_req, done 1 cycle after start).
//  3. op=E0 (d, unconditional), pc_cur=2000, mem AB,CD
//     -> link_load with link_addr=2002 one cycle before pc_load with pc_next=ABCD.
//  4. pc_cur=FFFF, op=C2 (nz), ccr=000, mem 00,10
//     -> reads at FFFF then 0000; pc_next=0010; taken=1.
//  5. 3 wait cycles on each ack; ccr toggled and start re-pulsed mid-fetch
//     -> mem_req/mem_addr held steady; snapshot is used; done 9 cycles after start.
//  6. reset_n asserted while in FETCH_LO -> all outputs 0 immediately; next start runs cleanly.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types and bit positions for the conditional GOTO sequencer and the
// decoder lookahead that reuses its condition evaluator.
package relay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        LINK,
        JUMP
    } gcs_state_t;

    // CCR layout is {carry, sign, zero}
    localparam int CCR_C = 2;
    localparam int CCR_S = 1;
    localparam int CCR_Z = 0;

    // Opcode layout is 11_d_s_c_z_nz_x
    localparam int OP_D  = 5;
    localparam int OP_S  = 4;
    localparam int OP_C  = 3;
    localparam int OP_Z  = 2;
    localparam int OP_NZ = 1;

endpackage

// File: rtl/goto_cond_eval.sv
// Combinational branch-condition evaluator: opcode condition bits vs. CCR.
// An opcode with no condition bits set is an unconditional branch.
module goto_cond_eval
    import relay_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [2:0] ccr,
    output logic       cond
);

    logic w_any_sel;
    logic w_hit;
    logic w_unused_op_bits;

    assign w_any_sel = |{opcode[OP_S], opcode[OP_C], opcode[OP_Z], opcode[OP_NZ]};

    assign w_hit = (opcode[OP_S]  &  ccr[CCR_S])
                 | (opcode[OP_C]  &  ccr[CCR_C])
                 | (opcode[OP_Z]  &  ccr[CCR_Z])
                 | (opcode[OP_NZ] & ~ccr[CCR_Z]);

    assign cond = ~w_any_sel | w_hit;

    // Class bits and the don't-care bit carry no condition information.
    assign w_unused_op_bits = ^{opcode[7:6], opcode[OP_D], opcode[0]};

endmodule

// File: rtl/goto_cond_sequencer.sv
// Executes the 3-byte conditional GOTO: fetches both operand bytes, evaluates
// the condition, optionally loads the link register, then loads the PC.
// Optional macro EARLY_EVAL_EN: evaluate at start and skip fetches when not taken.
module goto_cond_sequencer
    import relay_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        opcode,
    input  logic [2:0]        ccr,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              link_load,
    output logic [ADDR_W-1:0] link_addr,
    output logic              busy,
    output logic              done,
    output logic              taken
);

    gcs_state_t        r_state;
    gcs_state_t        w_next_state;

    logic [7:0]        r_opcode;
    logic [2:0]        r_ccr;
    logic [ADDR_W-1:0] r_op_ptr;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic [7:0]        w_eval_op;
    logic [2:0]        w_eval_ccr;
    logic              w_cond;
    logic [ADDR_W-1:0] w_ptr_inc;

    // In IDLE the live inputs are evaluated (early-eval lookahead); afterwards
    // only the snapshot taken at start matters.
    assign w_eval_op  = (r_state == IDLE) ? opcode : r_opcode;
    assign w_eval_ccr = (r_state == IDLE) ? ccr    : r_ccr;
    assign w_ptr_inc  = r_op_ptr + ADDR_W'(1);

    goto_cond_eval u_eval (
        .opcode (w_eval_op),
        .ccr    (w_eval_ccr),
        .cond   (w_cond)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_addr     = '0;
        pc_load      = 1'b0;
        pc_next      = '0;
        link_load    = 1'b0;
        link_addr    = '0;
        done         = 1'b0;
        taken        = 1'b0;
        busy         = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef EARLY_EVAL_EN
                    w_next_state = w_cond ? FETCH_HI : JUMP;
`else
                    w_next_state = FETCH_HI;
`endif
                end
            end
            FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = r_op_ptr;
                if (mem_ack) w_next_state = FETCH_LO;
            end
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = r_op_ptr;
                if (mem_ack) w_next_state = (w_cond && r_opcode[OP_D]) ? LINK : JUMP;
            end
            LINK: begin
                link_load    = 1'b1;
                link_addr    = w_ptr_inc;
                w_next_state = JUMP;
            end
            JUMP: begin
                pc_load      = 1'b1;
                done         = 1'b1;
                taken        = w_cond;
                pc_next      = w_cond ? {r_hi, r_lo} : w_ptr_inc;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // op_ptr ends at the lo-byte address, so op_ptr+1 is the next instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode <= '0;
            r_ccr    <= '0;
            r_op_ptr <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values regardless of statement order.
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opcode <= opcode;
                        r_ccr    <= ccr;
                        r_op_ptr <= (w_next_state == JUMP) ? pc_cur + ADDR_W'(1) : pc_cur;
                    end
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        r_hi     <= mem_data;
                        r_op_ptr <= w_ptr_inc;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) r_lo <= mem_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goto_cond_sequencer.sv
// Scoreboard bench for goto_cond_sequencer: stimulus pushes expected results
// and read addresses; monitor and memory-model processes pop and compare.
module tb_goto_cond_sequencer;

`ifdef EARLY_EVAL_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [15:0] pc;
        logic        tk;
        logic        link;
        logic [15:0] link_a;
        int          lat;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  opcode = '0;
    logic [2:0]  ccr = '0;
    logic [15:0] pc_cur = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        link_load;
    logic [15:0] link_addr;
    logic        busy;
    logic        done;
    logic        taken;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int wait_n = 0;
    int wait_cnt = 0;
    int link_cyc = -100;
    logic [15:0] link_seen = '0;
    logic [15:0] hold_addr = '0;

    logic [7:0]  mem [logic [15:0]];
    exp_t        exp_q[$];
    logic [15:0] exp_addr[$];

    goto_cond_sequencer #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .ccr       (ccr),
        .pc_cur    (pc_cur),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .pc_load   (pc_load),
        .pc_next   (pc_next),
        .link_load (link_load),
        .link_addr (link_addr),
        .busy      (busy),
        .done      (done),
        .taken     (taken)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: acks after wait_n wait cycles and checks read order.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_req) begin
            if (wait_cnt == 0) hold_addr = mem_addr;
            else check("mem_addr_hold", mem_addr, hold_addr);
            if (wait_cnt == wait_n) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr];
                if (exp_addr.size() == 0) check("read_expected", 0, 1);
                else check("read_addr", mem_addr, exp_addr.pop_front());
                wait_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (reset_n) begin
            if (link_load) begin
                link_cyc  = cyc;
                link_seen = link_addr;
            end
            if (done) begin
                check("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pc_next", pc_next, e.pc);
                    check("taken", taken, e.tk);
                    check("pc_load_with_done", pc_load, 1);
                    check("busy_at_done", busy, 1);
                    check("latency", cyc - e.t0, e.lat);
                    if (e.link) begin
                        check("link_before_jump", cyc - link_cyc, 1);
                        check("link_addr", link_seen, e.link_a);
                    end else begin
                        check("no_link", link_cyc >= e.t0, 0);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] op, input logic [2:0] c, input logic [15:0] pc,
                         input logic [7:0] hi, input logic [7:0] lo, input int wt,
                         input logic [15:0] pc_exp, input logic tk, input logic lnk,
                         input int lat, input bit fetch, input bit push);
        logic [15:0] pc1;
        exp_t e;
        pc1 = pc + 16'd1;
        mem[pc]  = hi;
        mem[pc1] = lo;
        wait_n   = wt;
        if (fetch) begin
            exp_addr.push_back(pc);
            exp_addr.push_back(pc1);
        end
        @(posedge clk);
        #1;
        opcode = op;
        ccr    = c;
        pc_cur = pc;
        start  = 1'b1;
        e.pc = pc_exp; e.tk = tk; e.link = lnk; e.link_a = pc + 16'd2;
        e.lat = lat; e.t0 = cyc;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        ccr    = ~c;
        opcode = 8'hFF;
        pc_cur = 16'hDEAD;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
        check("results_drained", exp_q.size(), 0);
        check("reads_drained", exp_addr.size(), 0);
        exp_q.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        #23;
        check("reset_outputs", {mem_req, mem_addr, pc_load, pc_next, link_load, link_addr,
                                busy, done, taken}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Unconditional, zero wait.
        issue(8'hC0, 3'b000, 16'h0100, 8'h12, 8'h34, 0, 16'h1234, 1, 0, 3, 1, 1);
        wait_done();
        // Z condition with zero clear: not taken.
        issue(8'hC4, 3'b000, 16'h0100, 8'h56, 8'h78, 0, 16'h0102, 0, 0,
              EARLY ? 1 : 3, !EARLY, 1);
        wait_done();
        // Call form, unconditional: link then jump.
        issue(8'hE0, 3'b000, 16'h2000, 8'hAB, 8'hCD, 0, 16'hABCD, 1, 1, 4, 1, 1);
        wait_done();
        // NZ across the address wrap.
        issue(8'hC2, 3'b000, 16'hFFFF, 8'h00, 8'h10, 0, 16'h0010, 1, 0, 3, 1, 1);
        wait_done();
        // S condition with sign set.
        issue(8'hD0, 3'b010, 16'h0200, 8'h77, 8'h66, 0, 16'h7766, 1, 0, 3, 1, 1);
        wait_done();
        // Call form with C condition false: no link, fall through.
        issue(8'hE8, 3'b000, 16'h0300, 8'h44, 8'h55, 0, 16'h0302, 0, 0,
              EARLY ? 1 : 3, !EARLY, 1);
        wait_done();
        // Fall-through across the wrap.
        issue(8'hC4, 3'b000, 16'hFFFF, 8'h99, 8'h88, 0, 16'h0001, 0, 0,
              EARLY ? 1 : 3, !EARLY, 1);
        wait_done();

        // Wait states, CCR toggled and start re-pulsed mid-fetch.
        issue(8'hC4, 3'b001, 16'h3000, 8'h9A, 8'hBC, 3, 16'h9ABC, 1, 0, 9, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        ccr    = 3'b000;
        opcode = 8'hC0;
        pc_cur = 16'h5555;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Reset while waiting in FETCH_LO.
        issue(8'hC0, 3'b000, 16'h4000, 8'h11, 8'h22, 4, 16'h1122, 1, 0, 3, 1, 0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h4001) found = 1'b1;
        end
        check("reached_fetch_lo", found, 1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_outputs", {mem_addr, pc_load, pc_next, link_load, link_addr, done, taken}, 0);
        exp_addr.delete();
        exp_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        issue(8'hC0, 3'b000, 16'h0100, 8'h12, 8'h34, 0, 16'h1234, 1, 0, 3, 1, 1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
